// File: rtl/instr_wb_pkg.sv
// Shared types and helpers for the pipelined Wishbone instrumentation slave.
// The request entry is sized from the default data/memory geometry below.
// Instances must keep DATA_WIDTH and MEM_WORDS at these values. LATENCY,
// DEPTH and ADDR_WIDTH are free per instance.
package instr_wb_pkg;

  localparam int DATA_W        = 32;
  localparam int SEL_W         = DATA_W / 8;
  localparam int MEM_WORDS_DEF = 64;
  localparam int IDX_W         = $clog2(MEM_WORDS_DEF);
  localparam int LATENCY_MAX   = 15;
  localparam int AGE_W         = $clog2(LATENCY_MAX + 1);

  typedef struct packed {
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } req_t;

  // Replace the selected byte lanes of old_w with the lanes of new_w.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_req_fifo.sv
// Circular request queue with a per-entry age counter.
// Ports:
//   clk_i, rst_ni   : clock and async active-low reset.
//   flush_i         : drop every queued entry at the next edge.
//   push_i/entry_i  : enqueue one request. The caller never pushes while full.
//   pop_i           : dequeue the head. Only issued when head_ready_o is high.
//   head_o          : oldest entry.
//   head_ready_o    : the head's response edge is the coming edge.
//   full_o, empty_o : occupancy flags from the registered count.
module instr_req_fifo
  import instr_wb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  req_t entry_i,
  input  logic pop_i,
  output req_t head_o,
  output logic head_ready_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(LATENCY);
  // An entry's age reads k during the cycle after the k-th edge since acceptance.
  // The response edge is acceptance+LATENCY-1, so the head is ready once its age
  // reaches LATENCY-2.
  localparam logic [AGE_W-1:0] AGE_READY = AGE_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  req_t             entry_q [DEPTH];
  logic [AGE_W-1:0] age_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign head_o       = entry_q[rd_ptr_q];
  assign head_ready_o = !empty_o && (age_q[rd_ptr_q] >= AGE_READY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_q[i] < AGE_SAT) age_q[i] <= age_q[i] + 1'b1;
      end
      if (push_i) begin
        age_q[wr_ptr_q] <= '0;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) entry_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/instr_wb_pipelined_slave.sv
// Wishbone B4 pipelined slave model. It has configurable response latency,
// multiple outstanding requests, stall injection and a byte-writable backing
// memory. Read data can be overridden with injected data.
// Ports:
//   clk_i, rst_ni                : clock and async active-low reset.
//   wb_adr_i/dat_i/we_i/sel_i    : request fields. The word index is taken from the address.
//   wb_stb_i, wb_cyc_i           : strobe and cycle. Dropping cyc flushes the queue.
//   wb_stall_o                   : combinational, stall_inject_i | queue full.
//   wb_ack_o, wb_dat_o           : registered response, one ack per request, in order.
//   stall_inject_i               : forces a stall this cycle.
//   inject_en_i, injected_data_i : read data override, sampled at the response edge.
//   ack_count_o                  : wrapping count of acks since reset.
module instr_wb_pipelined_slave
  import instr_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int DEPTH      = 4,
  parameter int MEM_WORDS  = MEM_WORDS_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  output logic                    wb_ack_o,
  input  logic                    wb_cyc_i,
  output logic                    wb_stall_o,
  input  logic                    stall_inject_i,
  input  logic                    inject_en_i,
  input  logic [DATA_WIDTH-1:0]   injected_data_i,
  output logic [31:0]             ack_count_o
);

  localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
  localparam bit BYPASS = (LATENCY == 1);

  req_t req_in, head, resp;
  logic head_ready, full, empty;
  logic accept, bypass, push, pop, resp_valid;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [31:0]           ack_count_q;

  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[ADDR_WIDTH-1:IDX_W+OFF_W], wb_adr_i[OFF_W-1:0]};

  assign req_in = '{we: wb_we_i, idx: wb_adr_i[IDX_W+OFF_W-1:OFF_W], dat: wb_dat_i, sel: wb_sel_i};

  instr_req_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (!wb_cyc_i),
    .push_i       (push),
    .entry_i      (req_in),
    .pop_i        (pop),
    .head_o       (head),
    .head_ready_o (head_ready),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    wb_stall_o = stall_inject_i | full;
    accept     = wb_cyc_i & wb_stb_i & !wb_stall_o;
    // With single-cycle latency an idle slave responds at the acceptance edge
    // itself, so the request skips the queue.
    bypass     = BYPASS && empty && accept;
    pop        = wb_cyc_i && head_ready;
    push       = accept && !bypass;
    resp_valid = pop || bypass;
    resp       = bypass ? req_in : head;
    dat_d      = inject_en_i ? injected_data_i : mem_q[resp.idx];
  end

  always_ff @(posedge clk_i) begin
    if (resp_valid && resp.we) mem_q[resp.idx] <= byte_merge(mem_q[resp.idx], resp.dat, resp.sel);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ack_count_q <= '0;
    end else begin
      ack_q <= resp_valid;
      if (resp_valid) begin
        dat_q       <= dat_d;
        ack_count_q <= ack_count_q + 32'd1;
      end
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign ack_count_o = ack_count_q;

endmodule

// File: tb/tb_instr_wb_pipelined_slave.sv
module tb_instr_wb_pipelined_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0, dat_i = '0, inj_data = '0;
  logic        we = 1'b0, stall_inject = 1'b0, inject_en = 1'b0;
  logic [3:0]  sel = '0;
  logic [3:0]  cyc_v = '0, stb_v = '0;
  logic [3:0]  ack_v, stall_v;
  logic [31:0] dat_o [4];
  logic [31:0] ack_cnt [4];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Instance g has LATENCY lat_of(g), DEPTH 4.
  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 8;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 8;
    instr_wb_pipelined_slave #(
      .DATA_WIDTH (32), .ADDR_WIDTH (32), .LATENCY (L), .DEPTH (4), .MEM_WORDS (64)
    ) u_dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .wb_adr_i        (adr),
      .wb_dat_o        (dat_o[g]),
      .wb_dat_i        (dat_i),
      .wb_we_i         (we),
      .wb_sel_i        (sel),
      .wb_stb_i        (stb_v[g]),
      .wb_ack_o        (ack_v[g]),
      .wb_cyc_i        (cyc_v[g]),
      .wb_stall_o      (stall_v[g]),
      .stall_inject_i  (stall_inject),
      .inject_en_i     (inject_en),
      .injected_data_i (inj_data),
      .ack_count_o     (ack_cnt[g])
    );
  end

  typedef struct {
    int          exp_edge;
    bit          we;
    int          idx;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          inj;
    logic [31:0] inj_dat;
  } exp_t;

  exp_t        sb [4][$];
  int          last_exp [4];
  logic [31:0] mdl_mem [4][64];
  logic [31:0] mdl_cnt [4];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  // Drive one request to instance d and hold it until accepted.
  task automatic wb_req(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s);
    bit   accepted;
    logic was_stall;
    exp_t e;
    accepted = 0;
    @(negedge clk);
    cyc_v[d] = 1'b1; stb_v[d] = 1'b1;
    we = w; adr = a; dat_i = wd; sel = s;
    for (int t = 0; t < 64; t++) begin
      #1;
      was_stall = stall_v[d];
      if (stall_inject) chk_eq("stall_follows_inject", stall_v[d], 1'b1);
      @(posedge clk);
      #1;
      if (!was_stall) begin
        e.exp_edge = edge_cnt + lat_of(d) - 1;
        if (e.exp_edge <= last_exp[d]) e.exp_edge = last_exp[d] + 1;
        last_exp[d] = e.exp_edge;
        e.we = w; e.idx = int'((a >> 2) & 32'd63); e.dat = wd; e.sel = s;
        e.inj = inject_en; e.inj_dat = inj_data;
        sb[d].push_back(e);
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    stb_v[d] = 1'b0;
    if (!accepted) chk_eq("accept_timeout", accepted, 1'b1);
  endtask

  task automatic wait_drain(input int d);
    for (int t = 0; t < 200; t++) begin
      if (sb[d].size() == 0) break;
      @(negedge clk);
    end
    chk_eq("drain", sb[d].size(), 0);
  endtask

  // Response monitor: in-order scoreboard, timing, data and ack count.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int g = 0; g < 4; g++) begin
        if (ack_v[g]) begin
          chk_eq("ack_has_pending", sb[g].size() > 0, 1'b1);
          if (sb[g].size() > 0) begin
            e = sb[g].pop_front();
            mdl_cnt[g] = mdl_cnt[g] + 32'd1;
            chk_eq("ack_edge", edge_cnt, e.exp_edge);
            chk_eq("ack_count", ack_cnt[g], mdl_cnt[g]);
            if (e.we) mdl_mem[g][e.idx] = mdl_merge(mdl_mem[g][e.idx], e.dat, e.sel);
            else chk_eq("rd_data", dat_o[g], e.inj ? e.inj_dat : mdl_mem[g][e.idx]);
          end
        end else if (sb[g].size() > 0 && sb[g][0].exp_edge <= edge_cnt) begin
          chk_eq("ack_missing", ack_v[g], 1'b1);
          void'(sb[g].pop_front());
        end
      end
    end
  end

  task automatic clear_model();
    for (int g = 0; g < 4; g++) begin
      sb[g].delete();
      last_exp[g] = 0;
      mdl_cnt[g]  = '0;
    end
  endtask

  logic [31:0] cnt_before;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk_eq("rst_ack", ack_v[g], 1'b0);
      chk_eq("rst_dat", dat_o[g], 32'h0);
      chk_eq("rst_cnt", ack_cnt[g], 32'h0);
      chk_eq("rst_stall", stall_v[g], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // LATENCY=1 injected read
    inject_en = 1'b1; inj_data = 32'hDEADBEEF;
    wb_req(0, 0, 32'h0000_000C, 32'h0, 4'hF);
    wait_drain(0);
    chk_eq("s1_count", ack_cnt[0], 32'd1);
    inject_en = 1'b0;

    // byte-lane write
    wb_req(0, 1, 32'h0000_001C, 32'h0000_0000, 4'hF);
    wb_req(0, 1, 32'h0000_001C, 32'hAABBCCDD, 4'b0101);
    wb_req(0, 0, 32'h0000_001C, 32'h0, 4'hF);
    wait_drain(0);

    // LATENCY=3 write then read back-to-back, then stall injection mid-burst
    wb_req(1, 1, 32'h0000_0010, 32'h11223344, 4'hF);
    wb_req(1, 0, 32'h0000_0010, 32'h0, 4'hF);
    wait_drain(1);
    fork
      begin
        repeat (2) @(negedge clk);
        stall_inject = 1'b1;
        repeat (2) @(negedge clk);
        stall_inject = 1'b0;
      end
      begin
        wb_req(1, 1, 32'h0000_0020, 32'h01020304, 4'hF);
        wb_req(1, 1, 32'h0000_0024, 32'hF0E0D0C0, 4'hF);
        wb_req(1, 0, 32'h0000_0020, 32'h0, 4'hF);
        wb_req(1, 0, 32'h0000_0024, 32'h0, 4'hF);
        wb_req(1, 0, 32'h0000_0110, 32'h0, 4'hF);  // aliases word 4
      end
    join
    wait_drain(1);

    // LATENCY=5 cyc drop discards queued requests
    wb_req(2, 1, 32'h0000_0014, 32'h12345678, 4'hF);
    wb_req(2, 0, 32'h0000_0014, 32'h0, 4'hF);
    wait_drain(2);
    cnt_before = ack_cnt[2];
    wb_req(2, 1, 32'h0000_0014, 32'hCAFEF00D, 4'hF);
    wb_req(2, 0, 32'h0000_0014, 32'h0, 4'hF);
    wb_req(2, 1, 32'h0000_0018, 32'h55555555, 4'hF);
    @(negedge clk);
    cyc_v[2] = 1'b0;
    sb[2].delete();
    last_exp[2] = 0;
    repeat (10) @(negedge clk);
    #1;
    chk_eq("flush_no_acks", ack_cnt[2], cnt_before);
    wb_req(2, 0, 32'h0000_0014, 32'h0, 4'hF);
    wait_drain(2);

    // LATENCY=8 fill to DEPTH
    wb_req(3, 1, 32'h0000_0000, 32'hA0A0A0A0, 4'hF);
    wb_req(3, 1, 32'h0000_0004, 32'hB1B1B1B1, 4'hF);
    wb_req(3, 1, 32'h0000_0008, 32'hC2C2C2C2, 4'hF);
    wb_req(3, 1, 32'h0000_000C, 32'hD3D3D3D3, 4'hF);
    @(negedge clk);
    #1;
    chk_eq("stall_when_full", stall_v[3], 1'b1);
    wb_req(3, 0, 32'h0000_0000, 32'h0, 4'hF);
    wb_req(3, 0, 32'h0000_0004, 32'h0, 4'hF);
    wait_drain(3);
    chk_eq("full_ack_count", ack_cnt[3], 32'd6);

    // async reset mid-burst, away from the clock edge
    inject_en = 1'b1; inj_data = 32'h5A5A_A5A5;
    wb_req(0, 0, 32'h0000_000C, 32'h0, 4'hF);
    wb_req(0, 0, 32'h0000_0008, 32'h0, 4'hF);
    #1;
    chk_eq("pre_reset_ack", ack_v[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("async_rst_ack", ack_v[0], 1'b0);
    chk_eq("async_rst_cnt", ack_cnt[0], 32'h0);
    chk_eq("async_rst_dat", dat_o[0], 32'h0);
    clear_model();
    cyc_v = '0;
    stb_v = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    inj_data = 32'hDEADBEEF;
    wb_req(0, 0, 32'h0000_000C, 32'h0, 4'hF);
    wait_drain(0);
    chk_eq("post_rst_count", ack_cnt[0], 32'd1);
    inject_en = 1'b0;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
